// File: rtl/axis_video_out.sv
// AXI-Stream 24-bit pixel sink locked to a free-running raster generator.
// Buffers beats in a small FIFO and drives RGB/DE/HSYNC/VSYNC.
module axis_video_out #(
    parameter int   H_ACTIVE   = 32,
    parameter int   H_FP       = 2,
    parameter int   H_SYNC     = 4,
    parameter int   H_BP       = 2,
    parameter int   V_ACTIVE   = 24,
    parameter int   V_FP       = 1,
    parameter int   V_SYNC     = 2,
    parameter int   V_BP       = 1,
    parameter int   FIFO_DEPTH = 16,
    parameter logic SYNC_POL   = 1'b1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          enable,
    input  logic [23:0]                   s_axis_tdata,
    input  logic                          s_axis_tvalid,
    output logic                          s_axis_tready,
    input  logic                          s_axis_tlast,
    input  logic                          s_axis_tuser,
    output logic [23:0]                   vid_rgb,
    output logic                          vid_de,
    output logic                          vid_hsync,
    output logic                          vid_vsync,
    output logic                          locked,
    output logic [15:0]                   underflow_count,
    output logic [15:0]                   resync_count,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW = $clog2(H_TOTAL);
    localparam int VW = $clog2(V_TOTAL);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam int HS_START = H_ACTIVE + H_FP;
    localparam int HS_END = HS_START + H_SYNC;
    localparam int VS_START = V_ACTIVE + V_FP;
    localparam int VS_END = VS_START + V_SYNC;

    typedef enum logic [1:0] {SEEK, WAIT_SOF, LOCKED} state_t;

    state_t state, state_n;

    logic [25:0]   mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [LW-1:0] count;
    logic          full, head_valid, push, pop;
    logic [25:0]   head;
    logic          head_user, head_last;
    logic [23:0]   head_data;

    logic [HW-1:0] h_cnt;
    logic [VW-1:0] v_cnt;
    logic          sof_pos, eol_pos, active, hs_on, vs_on;
    logic          mismatch, show, uf_evt, rs_evt;

    assign full       = (count == LW'(FIFO_DEPTH));
    assign head_valid = (count != '0);
    assign s_axis_tready = ~rst & ~full;
    assign push       = s_axis_tvalid & s_axis_tready;
    assign head       = mem[rd_ptr];
    assign head_user  = head[25];
    assign head_last  = head[24];
    assign head_data  = head[23:0];
    assign fifo_level = count;
    assign locked     = (state == LOCKED);

    assign sof_pos = (h_cnt == '0) && (v_cnt == '0);
    assign eol_pos = (h_cnt == HW'(H_ACTIVE - 1));
    assign active  = (h_cnt < HW'(H_ACTIVE)) && (v_cnt < VW'(V_ACTIVE));
    assign hs_on   = (h_cnt >= HW'(HS_START)) && (h_cnt < HW'(HS_END));
    assign vs_on   = (v_cnt >= VW'(VS_START)) && (v_cnt < VW'(VS_END));
    assign mismatch = (head_user != sof_pos) || (head_last != eol_pos);

    // Beat storage; contents need no reset since the pointers define validity
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= {s_axis_tuser, s_axis_tlast, s_axis_tdata};
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Free-running raster counters, parked at the origin while disabled
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (!enable) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (h_cnt == HW'(H_TOTAL - 1)) begin
            h_cnt <= '0;
            v_cnt <= (v_cnt == VW'(V_TOTAL - 1)) ? '0 : v_cnt + 1'b1;
        end else begin
            h_cnt <= h_cnt + 1'b1;
        end
    end

    // Lock state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= SEEK;
        else     state <= state_n;
    end

    // Lock decisions: pops, displayed beat and error events
    always_comb begin
        state_n = state;
        pop     = 1'b0;
        show    = 1'b0;
        uf_evt  = 1'b0;
        rs_evt  = 1'b0;
        if (!enable) begin
            state_n = SEEK;
        end else begin
            case (state)
                SEEK: begin
                    if (head_valid) begin
                        if (head_user) state_n = WAIT_SOF;
                        else           pop = 1'b1;
                    end
                end
                WAIT_SOF: begin
                    if (sof_pos && head_valid) begin
                        pop     = 1'b1;
                        show    = 1'b1;
                        state_n = LOCKED;
                        if (mismatch) begin
                            rs_evt  = 1'b1;
                            state_n = SEEK;
                        end
                    end
                end
                LOCKED: begin
                    if (active) begin
                        if (!head_valid) begin
                            uf_evt  = 1'b1;
                            state_n = SEEK;
                        end else begin
                            pop  = 1'b1;
                            show = 1'b1;
                            if (mismatch) begin
                                rs_evt  = 1'b1;
                                state_n = SEEK;
                            end
                        end
                    end
                end
                default: state_n = SEEK;
            endcase
        end
    end

    // Registered video pins, one clock behind the raster counters
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vid_rgb   <= '0;
            vid_de    <= 1'b0;
            vid_hsync <= ~SYNC_POL;
            vid_vsync <= ~SYNC_POL;
        end else begin
            vid_rgb   <= show ? head_data : 24'd0;
            vid_de    <= enable & active;
            vid_hsync <= (enable & hs_on) ? SYNC_POL : ~SYNC_POL;
            vid_vsync <= (enable & vs_on) ? SYNC_POL : ~SYNC_POL;
        end
    end

    // Saturating event counters
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            underflow_count <= '0;
            resync_count    <= '0;
        end else begin
            if (uf_evt && underflow_count != 16'hFFFF)
                underflow_count <= underflow_count + 16'd1;
            if (rs_evt && resync_count != 16'hFFFF)
                resync_count <= resync_count + 16'd1;
        end
    end

endmodule

// File: tb/tb_axis_video_out.sv
// Bench for axis_video_out: directed scenarios plus random framed traffic,
// checked every cycle against a queue-based reference model.
module tb_axis_video_out;

    localparam int HA = 4, HF = 1, HS = 1, HB = 1;
    localparam int VA = 3, VF = 1, VS = 1, VB = 1;
    localparam int DEPTH = 16;
    localparam logic POL = 1'b1;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;
    localparam int FRAME = HT * VT;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic [23:0] s_axis_tdata;
    logic        s_axis_tvalid;
    logic        s_axis_tready;
    logic        s_axis_tlast;
    logic        s_axis_tuser;
    logic [23:0] vid_rgb;
    logic        vid_de, vid_hsync, vid_vsync, locked;
    logic [15:0] underflow_count, resync_count;
    logic [4:0]  fifo_level;

    axis_video_out #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .FIFO_DEPTH(DEPTH), .SYNC_POL(POL)
    ) dut (
        .clk(clk), .rst(rst), .enable(enable),
        .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tready(s_axis_tready), .s_axis_tlast(s_axis_tlast),
        .s_axis_tuser(s_axis_tuser),
        .vid_rgb(vid_rgb), .vid_de(vid_de), .vid_hsync(vid_hsync),
        .vid_vsync(vid_vsync), .locked(locked),
        .underflow_count(underflow_count), .resync_count(resync_count),
        .fifo_level(fifo_level)
    );

    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail = 0;

    // Source beats waiting to be offered, and the model's view of the buffer
    logic [25:0] srcq[$];
    logic [25:0] mq[$];
    bit          gate;

    // Reference model: position in frame, lock mode (0 hunt, 1 armed, 2 tracking)
    int          pos;
    int          mode;
    logic [23:0] e_rgb;
    logic        e_de, e_hs, e_vs;
    int          e_uf, e_rs;
    int          obs_de, obs_hs, obs_vs;

    task automatic chk(input string tag, input logic [95:0] got,
                       input logic [95:0] exp);
        n_assert++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    function automatic logic [95:0] dut_vec();
        return {31'd0, vid_rgb, vid_de, vid_hsync, vid_vsync, locked,
                underflow_count, resync_count, fifo_level};
    endfunction

    function automatic logic [95:0] exp_vec();
        return {31'd0, e_rgb, e_de, e_hs, e_vs, (mode == 2),
                16'(e_uf), 16'(e_rs), 5'(mq.size())};
    endfunction

    task automatic add_frame(input int nb, input int bad, input bit rnd);
        for (int i = 0; i < nb; i++) begin
            int h, v;
            logic [23:0] d;
            logic u, l;
            h = i % HA;
            v = i / HA;
            d = rnd ? 24'($urandom) : 24'(v * HA + h);
            u = (i == 0);
            l = (h == HA - 1) ^ (i == bad);
            srcq.push_back({u, l, d});
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        enable = 1'b0;
        gate = 1'b0;
        s_axis_tvalid = 1'b0;
        s_axis_tdata = '0;
        s_axis_tuser = 1'b0;
        s_axis_tlast = 1'b0;
        srcq.delete();
        mq.delete();
        pos = 0;
        mode = 0;
        e_rgb = '0;
        e_de = 1'b0;
        e_hs = ~POL;
        e_vs = ~POL;
        e_uf = 0;
        e_rs = 0;
        #1;
        chk("rst_tready", 96'(s_axis_tready), 96'(0));
        @(posedge clk);
        #1;
        chk("rst_outputs", dut_vec(), exp_vec());
        rst = 1'b0;
        #1;
    endtask

    task automatic step();
        int h, v;
        bit act, sof, acc, fire, take;
        logic [25:0] b;
        s_axis_tvalid = gate && (srcq.size() > 0);
        if (s_axis_tvalid) begin
            s_axis_tdata = srcq[0][23:0];
            s_axis_tlast = srcq[0][24];
            s_axis_tuser = srcq[0][25];
        end else begin
            s_axis_tdata = '0;
            s_axis_tlast = 1'b0;
            s_axis_tuser = 1'b0;
        end
        #1;
        chk("tready", 96'(s_axis_tready), 96'(mq.size() < DEPTH));
        fire = s_axis_tvalid && s_axis_tready;
        h = pos % HT;
        v = pos / HT;
        act = enable && h < HA && v < VA;
        sof = (h == 0) && (v == 0);
        acc = s_axis_tvalid && (mq.size() < DEPTH);
        take = 1'b0;
        e_rgb = '0;
        if (!enable) begin
            mode = 0;
        end else if (mode == 0) begin
            if (mq.size() > 0) begin
                if (mq[0][25]) mode = 1;
                else void'(mq.pop_front());
            end
        end else if (mode == 1) begin
            if (sof && mq.size() > 0) take = 1'b1;
        end else if (act) begin
            if (mq.size() == 0) begin
                if (e_uf < 65535) e_uf++;
                mode = 0;
            end else begin
                take = 1'b1;
            end
        end
        if (take) begin
            b = mq.pop_front();
            e_rgb = b[23:0];
            mode = 2;
            if (b[25] != sof || b[24] != (h == HA - 1)) begin
                if (e_rs < 65535) e_rs++;
                mode = 0;
            end
        end
        if (acc) mq.push_back({s_axis_tuser, s_axis_tlast, s_axis_tdata});
        e_de = act;
        e_hs = (enable && h >= HA + HF && h < HA + HF + HS) ? POL : ~POL;
        e_vs = (enable && v >= VA + VF && v < VA + VF + VS) ? POL : ~POL;
        pos = enable ? (pos + 1) % FRAME : 0;
        @(posedge clk);
        #1;
        if (fire) void'(srcq.pop_front());
        chk("pins", dut_vec(), exp_vec());
        obs_de += int'(vid_de);
        obs_hs += int'(vid_hsync == POL);
        obs_vs += int'(vid_vsync == POL);
    endtask

    initial begin
        int nb, bad;
        rst = 1'b1;
        enable = 1'b0;
        gate = 1'b0;
        s_axis_tvalid = 1'b0;
        s_axis_tdata = '0;
        s_axis_tuser = 1'b0;
        s_axis_tlast = 1'b0;

        // Idle raster with no input
        do_reset();
        enable = 1'b1;
        obs_de = 0;
        obs_hs = 0;
        obs_vs = 0;
        repeat (FRAME) step();
        chk("idle_de_count", 96'(obs_de), 96'(HA * VA));
        chk("idle_hs_count", 96'(obs_hs), 96'(HS * VT));
        chk("idle_vs_count", 96'(obs_vs), 96'(VS * HT));
        chk("idle_locked", 96'(locked), 96'(0));
        repeat (FRAME) step();

        // Clean frames
        do_reset();
        enable = 1'b1;
        gate = 1'b1;
        add_frame(12, -1, 0);
        add_frame(12, -1, 0);
        add_frame(12, -1, 0);
        repeat (FRAME) step();
        chk("clean_prelock", 96'(locked), 96'(0));
        step();
        chk("clean_lock", 96'(locked), 96'(1));
        repeat (3 * FRAME - FRAME - 1) step();
        chk("clean_still_locked", 96'(locked), 96'(1));
        chk("clean_uf", 96'(underflow_count), 96'(0));
        chk("clean_rs", 96'(resync_count), 96'(0));

        // Garbage ahead of SOF
        do_reset();
        gate = 1'b1;
        srcq.push_back({2'b00, 24'h0000AA});
        srcq.push_back({2'b01, 24'h0000BB});
        srcq.push_back({2'b00, 24'h0000CC});
        add_frame(12, -1, 0);
        add_frame(12, -1, 0);
        repeat (15) step();
        chk("garb_level_full", 96'(fifo_level), 96'(15));
        gate = 1'b0;
        enable = 1'b1;
        repeat (3) step();
        chk("garb_level_drop", 96'(fifo_level), 96'(12));
        repeat (39) step();
        chk("garb_wait", 96'(locked), 96'(0));
        step();
        chk("garb_lock", 96'(locked), 96'(1));
        gate = 1'b1;
        repeat (60) step();
        chk("garb_uf", 96'(underflow_count), 96'(0));
        chk("garb_rs", 96'(resync_count), 96'(0));

        // Starve after 5 beats
        do_reset();
        gate = 1'b1;
        add_frame(5, -1, 0);
        repeat (5) step();
        enable = 1'b1;
        repeat (50) step();
        chk("starve_locked", 96'(locked), 96'(1));
        chk("starve_uf0", 96'(underflow_count), 96'(0));
        step();
        chk("starve_uf1", 96'(underflow_count), 96'(1));
        chk("starve_unlock", 96'(locked), 96'(0));
        add_frame(12, -1, 0);
        repeat (33) step();
        chk("starve_wait", 96'(locked), 96'(0));
        step();
        chk("starve_relock", 96'(locked), 96'(1));
        repeat (20) step();
        chk("starve_uf_final", 96'(underflow_count), 96'(1));

        // Early tlast on pixel 2
        do_reset();
        gate = 1'b1;
        add_frame(12, 2, 0);
        add_frame(12, -1, 0);
        repeat (12) step();
        enable = 1'b1;
        repeat (44) step();
        chk("tlast_locked", 96'(locked), 96'(1));
        chk("tlast_rs0", 96'(resync_count), 96'(0));
        step();
        chk("tlast_rs1", 96'(resync_count), 96'(1));
        chk("tlast_unlock", 96'(locked), 96'(0));
        repeat (40) step();
        chk("tlast_relock", 96'(locked), 96'(1));
        repeat (20) step();
        chk("tlast_rs_final", 96'(resync_count), 96'(1));
        chk("tlast_uf_final", 96'(underflow_count), 96'(0));

        // Fill while disabled, then drain at the active rate
        do_reset();
        gate = 1'b1;
        add_frame(12, -1, 0);
        add_frame(12, -1, 0);
        repeat (20) step();
        chk("fill_level", 96'(fifo_level), 96'(DEPTH));
        chk("fill_tready", 96'(s_axis_tready), 96'(0));
        gate = 1'b0;
        enable = 1'b1;
        repeat (43) step();
        chk("drain_first", 96'(fifo_level), 96'(15));
        repeat (6) step();
        chk("drain_line", 96'(fifo_level), 96'(12));
        repeat (35) step();
        chk("drain_frame", 96'(fifo_level), 96'(4));

        // Random framed traffic with corruption, enable toggles and a reset
        do_reset();
        enable = 1'b1;
        for (int i = 0; i < 900; i++) begin
            if (i == 450) begin
                do_reset();
                enable = 1'b1;
            end
            if ($urandom_range(0, 59) == 0) enable = ~enable;
            gate = ($urandom_range(0, 3) != 0);
            if (srcq.size() == 0) begin
                nb = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 12)) : 12;
                bad = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 11)) : -1;
                add_frame(nb, bad, 1);
                if ($urandom_range(0, 5) == 0) srcq.push_back({2'b00, 24'($urandom)});
            end
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
